// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router.
//
// Port indices (L, N, E, S, W), the crossbar idle select code, the output
// allocator state encoding and a small wrapping-increment helper.
package noc_pkg;

  localparam int unsigned N_PORTS = 5;

  localparam int unsigned PORT_L = 0;
  localparam int unsigned PORT_N = 1;
  localparam int unsigned PORT_E = 2;
  localparam int unsigned PORT_S = 3;
  localparam int unsigned PORT_W = 4;

  // Crossbar select value meaning "no input drives this output".
  localparam int unsigned SEL_IDLE = 5;

  // Two-bit encoding so there are spare codes; those recover to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOCKED = 2'b01
  } alloc_state_e;

  // Next port index after p, wrapping at n.
  function automatic int unsigned wrap_inc(int unsigned p, int unsigned n);
    return (p >= n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
//
// Ports:
//   e      in   N      request vector
//   ptr    in   IDX_W  highest-priority index this cycle
//   any    out  1      at least one request set
//   winner out  IDX_W  first set bit searching ptr, ptr+1, ... modulo N (0 when none)
module rr_pick
  import noc_pkg::*;
#(
  parameter int unsigned N     = N_PORTS,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     e,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  // Scan from the lowest priority towards ptr so the last hit is the winner.
  always_comb begin
    logic [IDX_W-1:0] idx;
    any    = |e;
    winner = '0;
    idx    = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % int'(N));
      if (e[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output switch allocator for the 5-port mesh router.
//
// Round-robin arbitration among input ports whose head flit is routed to this
// output; the winner owns the output until its tail flit moves. Transfers are
// gated by a downstream credit counter.
//
// Optional build macro ALLOC_CREDIT_CHK_EN adds the sticky credit_err output.
//
// Ports:
//   clk        in   1          clock, rising edge
//   rst        in   1          asynchronous active-high reset
//   req        in   N_PORTS    input i's front flit is routed here
//   in_valid   in   N_PORTS    input i's front flit is present
//   in_head    in   N_PORTS    input i's front flit is a head
//   in_tail    in   N_PORTS    input i's front flit is a tail
//   credit_ret in   1          downstream freed one slot (pulse)
//   select     out  N_BIT_SEL  crossbar select; owner index or SEL_IDLE
//   grant      out  N_PORTS    one-hot owner, zero when idle
//   xfer       out  1          flit moves this cycle; pop strobe to owner
//   credits    out  CNT_W      current credit count
//   credit_err out  1          (ALLOC_CREDIT_CHK_EN only) sticky protocol error
module noc_output_allocator
  import noc_pkg::alloc_state_e;
  import noc_pkg::ST_IDLE;
  import noc_pkg::ST_LOCKED;
  import noc_pkg::SEL_IDLE;
  import noc_pkg::wrap_inc;
#(
  parameter int unsigned N_PORTS      = 5,
  parameter int unsigned N_BIT_SEL    = 3,
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   req,
  input  logic [N_PORTS-1:0]   in_valid,
  input  logic [N_PORTS-1:0]   in_head,
  input  logic [N_PORTS-1:0]   in_tail,
  input  logic                 credit_ret,
  output logic [N_BIT_SEL-1:0] select,
  output logic [N_PORTS-1:0]   grant,
  output logic                 xfer,
  output logic [CNT_W-1:0]     credits
`ifdef ALLOC_CREDIT_CHK_EN
  ,
  output logic                 credit_err
`endif
);

  localparam int unsigned PTR_W = $clog2(N_PORTS);
  localparam logic [N_BIT_SEL-1:0] SEL_IDLE_V = N_BIT_SEL'(SEL_IDLE);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDIT_DEPTH);

  alloc_state_e         state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     credits_d;
  logic [N_PORTS-1:0]   elig;
  logic                 any_elig;
  logic [PTR_W-1:0]     win_idx;
  logic                 locked;
  logic                 own_valid;
  logic                 own_tail;
  logic                 release_pkt;
  logic [PTR_W-1:0]     ptr_next;

  assign elig = req & in_valid & in_head;

  rr_pick #(
    .N     (N_PORTS),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .e      (elig),
    .ptr    (ptr_q),
    .any    (any_elig),
    .winner (win_idx)
  );

  assign locked = (state_q == ST_LOCKED);

  // grant is the registered one-hot owner, so it doubles as the owner mux.
  assign own_valid   = |(grant & in_valid);
  assign own_tail    = |(grant & in_tail);
  assign xfer        = locked & own_valid & (credits != '0);
  assign release_pkt = xfer & own_tail;
  assign ptr_next    = PTR_W'(wrap_inc(int'(select), N_PORTS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      select  <= SEL_IDLE_V;
      grant   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q <= ST_LOCKED;
            select  <= N_BIT_SEL'(win_idx);
            grant   <= N_PORTS'(1) << win_idx;
          end
        end
        ST_LOCKED: begin
          // Stalled owners keep the lock; only the tail transfer releases it.
          if (release_pkt) begin
            state_q <= ST_IDLE;
            select  <= SEL_IDLE_V;
            grant   <= '0;
            ptr_q   <= ptr_next;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          select  <= SEL_IDLE_V;
          grant   <= '0;
        end
      endcase
    end
  end

  // Simultaneous transfer and return cancel; returns saturate at the ceiling.
  always_comb begin
    credits_d = credits;
    if (xfer && !credit_ret) begin
      credits_d = credits - 1'b1;
    end else if (credit_ret && !xfer && (credits != CRED_MAX)) begin
      credits_d = credits + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CRED_MAX;
    end else begin
      credits <= credits_d;
    end
  end

`ifdef ALLOC_CREDIT_CHK_EN
  logic own_head;
  logic moved_q;
  logic err_set;

  assign own_head = |(grant & in_head);

  // A head showing up on the owner after the packet started means its tail was lost.
  assign err_set = (credit_ret & ~xfer & (credits == CRED_MAX)) |
                   (locked & moved_q & own_valid & own_head);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moved_q    <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      moved_q    <= locked & ~release_pkt & (moved_q | xfer);
      credit_err <= credit_err | err_set;
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_allocator.sv
module tb_noc_output_allocator;

  localparam int NP    = 5;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] in_valid = '0;
  logic [4:0] in_head = '0;
  logic [4:0] in_tail = '0;
  logic       credit_ret = 1'b0;
  logic [2:0] select;
  logic [4:0] grant;
  logic       xfer;
  logic [2:0] credits;
`ifdef ALLOC_CREDIT_CHK_EN
  logic       credit_err;
`endif

  noc_output_allocator #(
    .N_PORTS      (NP),
    .N_BIT_SEL    (3),
    .CREDIT_DEPTH (DEPTH),
    .CNT_W        (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .in_valid   (in_valid),
    .in_head    (in_head),
    .in_tail    (in_tail),
    .credit_ret (credit_ret),
    .select     (select),
    .grant      (grant),
    .xfer       (xfer),
    .credits    (credits)
`ifdef ALLOC_CREDIT_CHK_EN
    ,
    .credit_err (credit_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit head; bit tail; bit rq;} flit_t;
  typedef struct {bit xf; int sel; bit [4:0] gnt; int cr; bit err;} snap_t;
  typedef struct {int port; int cr;} xrec_t;

  flit_t fifo[NP][$];
  snap_t snap_q[$];
  xrec_t xq[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: packet-level owner, priority pointer, credit count.
  int m_owner = -1;
  int m_ptr = 0;
  int m_cred = DEPTH;
  int m_moved = 0;
  bit m_err = 0;
  bit m_xfer = 0;
  int m_win = -1;
  bit c_tail = 0;
  bit c_cr = 0;
  bit c_errset = 0;
  bit [4:0] c_other = '0;

  bit want_rst = 0;
  bit force_cr = 0;
  int cr_pct = 0;
  int vld_pct = 100;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cred = DEPTH; m_moved = 0; m_err = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst) begin
      rst = 1'b0;
    end else begin
      if (m_xfer && fifo[m_owner].size() > 0) void'(fifo[m_owner].pop_front());
      for (int i = 0; i < NP; i++)
        if (c_other[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      if (m_xfer && !c_cr) m_cred--;
      else if (c_cr && !m_xfer && m_cred < DEPTH) m_cred++;
      if (c_errset) m_err = 1;
      if (m_owner < 0) begin
        if (m_win >= 0) begin m_owner = m_win; m_moved = 0; end
      end else if (m_xfer && c_tail) begin
        m_ptr = (m_owner + 1) % NP;
        m_owner = -1;
      end else if (m_xfer) begin
        m_moved++;
      end
    end
    if (want_rst) begin
      want_rst = 0;
      rst = 1'b1;
      model_reset();
    end
    // Drive inputs; fields of absent flits are random noise.
    for (int i = 0; i < NP; i++) begin
      if (fifo[i].size() > 0 && $urandom_range(99) < vld_pct) begin
        in_valid[i] = 1'b1;
        in_head[i] = fifo[i][0].head;
        in_tail[i] = fifo[i][0].tail;
        req[i] = fifo[i][0].rq;
      end else begin
        in_valid[i] = 1'b0;
        in_head[i] = 1'($urandom);
        in_tail[i] = 1'($urandom);
        req[i] = 1'($urandom);
      end
      c_other[i] = in_valid[i] && !req[i] && ($urandom_range(1) == 1);
    end
    credit_ret = force_cr || (m_cred < DEPTH && $urandom_range(99) < cr_pct);
    force_cr = 0;
    #1;
    m_win = -1;
    if (m_owner < 0 && !rst)
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (m_win < 0 && in_valid[p] && req[p] && in_head[p]) m_win = p;
      end
    m_xfer = (m_owner >= 0) && in_valid[m_owner] && (m_cred != 0);
    c_tail = m_xfer && in_tail[m_owner];
    c_cr = credit_ret;
    c_errset = (credit_ret && !m_xfer && m_cred == DEPTH) ||
               (m_owner >= 0 && m_moved > 0 && in_valid[m_owner] && in_head[m_owner]);
    snap_q.push_back('{xf: m_xfer, sel: (m_owner < 0) ? 5 : m_owner,
                       gnt: (m_owner < 0) ? 5'b0 : 5'(1 << m_owner), cr: m_cred, err: m_err});
    if (m_xfer) xq.push_back('{port: m_owner, cr: m_cred});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0);
    for (int i = 0; i < NP; i++) if (fifo[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int budget, input string tag);
    int c;
    c = 0;
    while (busy() && c < budget) begin cycle(); c++; end
    n_cmp++;
    if (busy()) begin
      n_bad++;
      $display("FAIL drain_%s: still busy after %0d cycles, required idle", tag, budget);
    end
  endtask

  task automatic refill();
    int c;
    c = 0;
    cr_pct = 100;
    while (m_cred < DEPTH && c < 20) begin cycle(); c++; end
    cycle();
  endtask

  task automatic send(input int port, input int len, input bit rq);
    for (int j = 0; j < len; j++)
      fifo[port].push_back('{head: (j == 0), tail: (j == len - 1), rq: rq});
  endtask

  // Monitor: per-cycle snapshot check, plus transfer scoreboard on every xfer.
  initial begin
    snap_t s;
    xrec_t r;
    bit err_bad;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        err_bad = 0;
`ifdef ALLOC_CREDIT_CHK_EN
        err_bad = (credit_err !== s.err);
`endif
        n_cmp++;
        if (xfer !== s.xf || int'(select) != s.sel || grant !== s.gnt ||
            int'(credits) != s.cr || err_bad) begin
          n_bad++;
          $display("FAIL cycle_state @%0t: got xfer=%b sel=%0d grant=%b cred=%0d, required xfer=%b sel=%0d grant=%b cred=%0d err=%b",
                   $time, xfer, select, grant, credits, s.xf, s.sel, s.gnt, s.cr, s.err);
        end
      end
      if (xfer === 1'b1) begin
        n_cmp++;
        if (xq.size() == 0) begin
          n_bad++;
          $display("FAIL xfer_unexpected @%0t: got xfer from sel=%0d, required none", $time, select);
        end else begin
          r = xq.pop_front();
          if (int'(select) != r.port || int'(credits) != r.cr) begin
            n_bad++;
            $display("FAIL xfer_record @%0t: got sel=%0d cred=%0d, required sel=%0d cred=%0d",
                     $time, select, credits, r.port, r.cr);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    cycle();

    // Single 3-flit packet on E, no credit returns.
    send(2, 3, 1);
    cr_pct = 0;
    run(7);
    refill();

    // Contention from ptr=0: L, S, W; then L alone and L+N (N wins at ptr=1).
    want_rst = 1;
    cycle();
    cr_pct = 50;
    send(0, 1, 1); send(3, 1, 1); send(4, 1, 1);
    drain(40, "contention");
    send(0, 1, 1);
    drain(20, "lone_l");
    send(0, 1, 1); send(1, 1, 1);
    drain(30, "l_n");

    // Credit stall: 6-flit packet on S with no returns, then one return.
    refill();
    cr_pct = 0;
    send(3, 6, 1);
    run(10);
    force_cr = 1;
    run(3);
    cr_pct = 60;
    drain(60, "stall");

    // Wrap-around: W releases, then L and W contend.
    send(4, 1, 1);
    drain(20, "w_alone");
    send(0, 2, 1); send(4, 2, 1);
    drain(40, "wrap");

    // Mid-packet reset on a 4-flit N packet after two flits.
    refill();
    cr_pct = 0;
    send(1, 4, 1);
    for (int c = 0; c < 20 && fifo[1].size() > 2; c++) cycle();
    for (int i = 0; i < NP; i++) fifo[i].delete();
    want_rst = 1;
    cycle();
    cycle();
    send(2, 1, 1);
    cr_pct = 50;
    drain(20, "after_reset");

    // Credit return while already full: saturates (and flags when checking is built in).
    refill();
    cr_pct = 0;
    force_cr = 1;
    run(3);

    // Random traffic.
    cr_pct = 50;
    vld_pct = 80;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(9) == 0) begin
        int p;
        p = $urandom_range(NP - 1);
        if (fifo[p].size() < 12) send(p, $urandom_range(5, 1), $urandom_range(9) < 8);
      end
      cycle();
    end
    drain(800, "random");

    want_rst = 1;
    cycle();
    run(2);

    @(negedge clk);
    #1;
    n_cmp++;
    if (xq.size() != 0 || snap_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: %0d transfers and %0d snapshots left, required 0",
               xq.size(), snap_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
